// File: rtl/grayscale_pipe.sv
// Purpose: pipelined RGB-to-grayscale converter; per-pixel mode (luminosity, average, max, bypass).
// Latency: 2 cycles from input acceptance to O_OUT_VALID when not stalled; 1 pixel/cycle throughput.
// Backpressure: O_IN_READY = ~O_OUT_VALID | I_OUT_READY; when low, every stage holds.
//
// Ports:
//   I_CLK, I_RESET         clock, synchronous active-high reset
//   I_MODE                 0 luminosity, 1 average, 2 max, 3 bypass; travels with its pixel
//   I_PIXEL/I_IN_VALID     input pixel {R,G,B} (R in MSBs) and its valid; O_IN_READY accepts it
//   O_PIXEL/O_OUT_VALID    output pixel {Y,Y,Y} (or original in bypass); I_OUT_READY accepts it
//   O_PIXEL_COUNT          output transfers since reset, wraps
module grayscale_pipe #(
  parameter int P_PIXEL_DEPTH = 24,  // must be a multiple of 3
  parameter int P_COUNT_WIDTH = 32
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic [1:0]               I_MODE,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  input  logic                     I_IN_VALID,
  output logic                     O_IN_READY,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
  output logic                     O_OUT_VALID,
  input  logic                     I_OUT_READY,
  output logic [P_COUNT_WIDTH-1:0] O_PIXEL_COUNT
);

  localparam int C  = P_PIXEL_DEPTH / 3;
  localparam int PW = C + 8;   // weighted product width
  localparam int SW = C + 2;   // R+G+B width
  localparam int LW = C + 10;  // luminosity sum width, headroom over 256*(2^C-1)
  localparam int AW = C + 10;  // (R+G+B)*171 width

  localparam logic [1:0] MODE_LUM = 2'd0;
  localparam logic [1:0] MODE_AVG = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  // S1 stage
  logic                     s1_vld_q,  s1_vld_d;
  logic [PW-1:0]            s1_pr_q,   s1_pr_d;
  logic [PW-1:0]            s1_pg_q,   s1_pg_d;
  logic [PW-1:0]            s1_pb_q,   s1_pb_d;
  logic [SW-1:0]            s1_sum_q,  s1_sum_d;
  logic [C-1:0]             s1_max_q,  s1_max_d;
  logic [P_PIXEL_DEPTH-1:0] s1_pix_q,  s1_pix_d;
  logic [1:0]               s1_mode_q, s1_mode_d;

  // S2 stage (output register)
  logic                     out_vld_q, out_vld_d;
  logic [P_PIXEL_DEPTH-1:0] out_pix_q, out_pix_d;
  logic [P_COUNT_WIDTH-1:0] cnt_q,     cnt_d;

  logic                     adv;
  logic [C-1:0]             in_r, in_g, in_b;
  logic [LW-1:0]            lum_sum;
  logic [AW-1:0]            avg_prod;
  logic [C:0]               avg_shr;
  logic [C-1:0]             y_lum, y_avg, gray;

  assign adv         = ~out_vld_q | I_OUT_READY;
  assign O_IN_READY  = adv;
  assign O_OUT_VALID = out_vld_q;
  assign O_PIXEL     = out_pix_q;
  assign O_PIXEL_COUNT = cnt_q;

  assign in_r = I_PIXEL[3*C-1:2*C];
  assign in_g = I_PIXEL[2*C-1:C];
  assign in_b = I_PIXEL[C-1:0];

  // S2 arithmetic on the S1 registers
  always_comb begin
    lum_sum  = LW'(s1_pr_q) + LW'(s1_pg_q) + LW'(s1_pb_q);
    y_lum    = lum_sum[C+7:8];
    avg_prod = AW'(s1_sum_q) * AW'(171);
    avg_shr  = avg_prod[AW-1:9];
    // 171/512 slightly exceeds 1/3, so wide channels can overshoot full scale
    y_avg    = avg_shr[C] ? {C{1'b1}} : avg_shr[C-1:0];
    case (s1_mode_q)
      MODE_LUM: gray = y_lum;
      MODE_AVG: gray = y_avg;
      default:  gray = s1_max_q;
    endcase
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_pr_d   = s1_pr_q;
    s1_pg_d   = s1_pg_q;
    s1_pb_d   = s1_pb_q;
    s1_sum_d  = s1_sum_q;
    s1_max_d  = s1_max_q;
    s1_pix_d  = s1_pix_q;
    s1_mode_d = s1_mode_q;
    out_vld_d = out_vld_q;
    out_pix_d = out_pix_q;
    cnt_d     = cnt_q;

    if (out_vld_q && I_OUT_READY) begin
      cnt_d = cnt_q + P_COUNT_WIDTH'(1);
    end

    if (adv) begin
      // S1 <- input; a bubble only clears the valid, data is left untouched
      s1_vld_d = I_IN_VALID;
      if (I_IN_VALID) begin
        s1_pr_d   = PW'(in_r) * PW'(77);
        s1_pg_d   = PW'(in_g) * PW'(150);
        s1_pb_d   = PW'(in_b) * PW'(29);
        s1_sum_d  = SW'(in_r) + SW'(in_g) + SW'(in_b);
        s1_max_d  = (in_r >= in_g) ? ((in_r >= in_b) ? in_r : in_b)
                                   : ((in_g >= in_b) ? in_g : in_b);
        s1_pix_d  = I_PIXEL;
        s1_mode_d = I_MODE;
      end
      // S2 <- S1
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_pix_d = (s1_mode_q == 2'd3) ? s1_pix_q : {3{gray}};
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s1_vld_q  <= 1'b0;
      s1_pr_q   <= '0;
      s1_pg_q   <= '0;
      s1_pb_q   <= '0;
      s1_sum_q  <= '0;
      s1_max_q  <= '0;
      s1_pix_q  <= '0;
      s1_mode_q <= '0;
      out_vld_q <= 1'b0;
      out_pix_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_pr_q   <= s1_pr_d;
      s1_pg_q   <= s1_pg_d;
      s1_pb_q   <= s1_pb_d;
      s1_sum_q  <= s1_sum_d;
      s1_max_q  <= s1_max_d;
      s1_pix_q  <= s1_pix_d;
      s1_mode_q <= s1_mode_d;
      out_vld_q <= out_vld_d;
      out_pix_q <= out_pix_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Purpose: directed self-checking bench for grayscale_pipe (24-bit/32-bit count and 48-bit/3-bit count).
// Latency: checks the 2-cycle pipeline latency and output ordering.
// Backpressure: exercises stalls, hold stability, reset mid-stall and counter wrap.
module tb_grayscale_pipe;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // 24-bit instance
  logic [1:0]  a_mode;
  logic [23:0] a_pix;
  logic        a_ivld, a_irdy, a_ovld, a_ordy;
  logic [23:0] a_opix;
  logic [31:0] a_cnt;

  // 48-bit instance, 3-bit counter
  logic [1:0]  b_mode;
  logic [47:0] b_pix;
  logic        b_ivld, b_irdy, b_ovld, b_ordy;
  logic [47:0] b_opix;
  logic [2:0]  b_cnt;

  grayscale_pipe dut_a (
    .I_CLK(clk), .I_RESET(rst), .I_MODE(a_mode), .I_PIXEL(a_pix),
    .I_IN_VALID(a_ivld), .O_IN_READY(a_irdy), .O_PIXEL(a_opix),
    .O_OUT_VALID(a_ovld), .I_OUT_READY(a_ordy), .O_PIXEL_COUNT(a_cnt)
  );

  grayscale_pipe #(.P_PIXEL_DEPTH(48), .P_COUNT_WIDTH(3)) dut_b (
    .I_CLK(clk), .I_RESET(rst), .I_MODE(b_mode), .I_PIXEL(b_pix),
    .I_IN_VALID(b_ivld), .O_IN_READY(b_irdy), .O_PIXEL(b_opix),
    .O_OUT_VALID(b_ovld), .I_OUT_READY(b_ordy), .O_PIXEL_COUNT(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Back-to-back mode sweep
  logic [23:0] px2  [5] = '{24'hFF7F00, 24'hFF7F00, 24'hFF7F00, 24'hFFFFFF, 24'h010101};
  logic [1:0]  md2  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [23:0] exp2 [5] = '{24'h7F7F7F, 24'hFFFFFF, 24'hFF7F00, 24'hFFFFFF, 24'h010101};

  // Stream under random-looking backpressure
  logic [23:0] px3  [8] = '{24'h102030, 24'h808080, 24'h00FF00, 24'h306090,
                            24'hFF0000, 24'h12AB34, 24'h123456, 24'h0000FF};
  logic [1:0]  md3  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [23:0] exp3 [8] = '{24'h1D1D1D, 24'h808080, 24'h959595, 24'h606060,
                            24'h555555, 24'hABABAB, 24'h123456, 24'h1C1C1C};
  logic [31:0] rdy_pat = 32'b1011_0010_1110_0101_1001_1101_0110_0011;
  logic [31:0] gap_pat = 32'b1101_1011_0111_1010_1111_0110_1101_1011;

  // Wide-channel vectors
  logic [47:0] px5  [4] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h1000_1000_1000, 48'h0001_0002_0003};
  logic [1:0]  md5  [4] = '{2'd1, 2'd0, 2'd1, 2'd3};
  logic [47:0] exp5 [3] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h1008_1008_1008};

  int          sent, recv, acc, stale, idx;
  logic        in_x, stalled;
  logic [23:0] held;

  initial begin
    rst = 1'b1;
    a_mode = 2'd0; a_pix = '0; a_ivld = 1'b0; a_ordy = 1'b1;
    b_mode = 2'd0; b_pix = '0; b_ivld = 1'b0; b_ordy = 1'b1;
    tick;
    tick;

    // Reset state
    check("rst_ovld", a_ovld, 1'b0);
    check("rst_opix", a_opix, 24'h0);
    check("rst_cnt",  a_cnt,  32'd0);
    check("rst_irdy", a_irdy, 1'b1);
    rst = 1'b0;

    // Single luminosity pixel, 2-cycle latency
    a_pix = 24'hFF7F00; a_mode = 2'd0; a_ivld = 1'b1;
    tick;
    a_ivld = 1'b0;
    check("t1_early_vld", a_ovld, 1'b0);
    tick;
    check("t1_vld", a_ovld, 1'b1);
    check("t1_pix", a_opix, 24'h979797);
    tick;
    check("t1_cnt", a_cnt, 32'd1);
    check("t1_drained", a_ovld, 1'b0);

    // Mode sweep back-to-back
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        a_ivld = 1'b1; a_pix = px2[i]; a_mode = md2[i];
      end else begin
        a_ivld = 1'b0;
      end
      tick;
      if (i >= 1) begin
        check("t2_vld", a_ovld, 1'b1);
        check("t2_pix", a_opix, exp2[i-1]);
      end
    end
    tick;
    check("t2_cnt", a_cnt, 32'd6);
    check("t2_drained", a_ovld, 1'b0);

    // Gapped stream with toggling ready
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      idx    = (sent < 8) ? sent : 0;
      a_ordy = rdy_pat[cyc % 32];
      a_ivld = (sent < 8) && gap_pat[cyc % 32];
      a_pix  = px3[idx];
      a_mode = md3[idx];
      #1;
      in_x = a_ivld && a_irdy;
      if (a_ovld && a_ordy) begin
        check("t3_data", a_opix, exp3[recv]);
        recv++;
      end
      stalled = a_ovld && !a_ordy;
      held    = a_opix;
      tick;
      if (stalled) check("t3_hold", {a_ovld, a_opix}, {1'b1, held});
      if (in_x) sent++;
    end
    a_ivld = 1'b0;
    a_ordy = 1'b1;
    check("t3_done", recv, 8);
    check("t3_cnt", a_cnt, 32'd8);

    // Full stall: only two pixels fit
    a_ordy = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      a_ivld = 1'b1;
      a_pix  = (acc == 0) ? 24'hFF7F00 : 24'h010101;
      a_mode = (acc == 0) ? 2'd2 : 2'd3;
      #1;
      if (a_irdy) acc++;
      tick;
    end
    a_ivld = 1'b0;
    check("t4_accepted", acc, 2);
    check("t4_irdy", a_irdy, 1'b0);
    check("t4_first", {a_ovld, a_opix}, {1'b1, 24'hFFFFFF});
    a_ordy = 1'b1;
    tick;
    check("t4_second", {a_ovld, a_opix}, {1'b1, 24'h010101});
    tick;
    check("t4_drained", a_ovld, 1'b0);
    check("t4_cnt", a_cnt, 32'd10);

    // Reset with two pixels in flight behind a stall
    a_ordy = 1'b0;
    a_ivld = 1'b1; a_pix = 24'h123456; a_mode = 2'd3;
    tick;
    a_pix = 24'h654321;
    tick;
    a_ivld = 1'b0;
    check("t6_pre_vld", a_ovld, 1'b1);
    rst = 1'b1;
    tick;
    check("t6_ovld", a_ovld, 1'b0);
    check("t6_opix", a_opix, 24'h0);
    check("t6_cnt",  a_cnt,  32'd0);
    rst = 1'b0;
    a_ordy = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (a_ovld) stale++;
    end
    check("t6_no_stale", stale, 0);

    // Wide channels: saturation, luminosity, average, then counter wrap
    for (int i = 0; i < 11; i++) begin
      if (i < 9) begin
        b_ivld = 1'b1;
        b_pix  = px5[(i < 3) ? i : 3];
        b_mode = md5[(i < 3) ? i : 3];
      end else begin
        b_ivld = 1'b0;
      end
      tick;
      if (i >= 1 && i <= 3) check("t5_pix", {b_ovld, b_opix}, {1'b1, exp5[i-1]});
    end
    check("t5_wrap_cnt", b_cnt, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grayscale_pipe.md
Name: grayscale_pipe

Overview:
Parametrised, pipelined successor to the combinational grayscale stage. It converts a stream of packed RGB pixels to grayscale, with a per-pixel selectable conversion mode and a valid/ready handshake with back-pressure. It sits between the pixel input buffer and the Gaussian/Sobel stages. The gray value is replicated into every channel of the output pixel, so the downstream pixel width is unchanged.

Parameters:
P_PIXEL_DEPTH, 24, packed pixel width; must be a multiple of 3; channel width C = P_PIXEL_DEPTH/3; packing {R,G,B}, R in the MSBs.
P_COUNT_WIDTH, 32, width of the output pixel counter.

Ports:
I_CLK  in  1  clock
I_RESET  in  1  synchronous active-high reset
I_MODE  in  2  conversion mode, sampled with each accepted pixel: 0 luminosity, 1 average, 2 max, 3 bypass
I_PIXEL  in  P_PIXEL_DEPTH  input pixel {R,G,B}
I_IN_VALID  in  1  input pixel valid
O_IN_READY  out  1  block can accept a pixel this cycle
O_PIXEL  out  P_PIXEL_DEPTH  output pixel; gray replicated {Y,Y,Y}, or the original pixel in bypass
O_OUT_VALID  out  1  O_PIXEL valid
I_OUT_READY  in  1  downstream accepts O_PIXEL
O_PIXEL_COUNT  out  P_COUNT_WIDTH  number of output pixels accepted downstream since reset

Behaviour:
- Clock and reset: single clock I_CLK. Reset is synchronous and active-high on I_RESET.
- Reset values: all stage valids 0; O_OUT_VALID=0; O_PIXEL=0; O_PIXEL_COUNT=0. O_IN_READY=1 in the first cycle after reset. Reset mid-operation discards all in-flight pixels; nothing is emitted for them.
- Pipeline: two register stages (S1, S2); latency is 2 cycles from input acceptance to O_OUT_VALID when not stalled.
- Transfers:
  - Input transfer = I_IN_VALID & O_IN_READY.
  - Output transfer = O_OUT_VALID & I_OUT_READY.
- Advance enable: adv = ~O_OUT_VALID | I_OUT_READY. O_IN_READY = adv, combinational. On adv, S2<=S1 and S1<=input; each stage valid moves with its data.
- Bubbles: when I_IN_VALID=0 on an adv cycle, a bubble (valid 0) enters S1.
- Stall: when adv=0, all stage registers hold, and O_PIXEL and O_OUT_VALID stay stable.
- No loss or duplication: no pixel is dropped or duplicated under any valid/ready pattern. Full throughput is 1 pixel/cycle while I_OUT_READY=1.
- S1 registers:
  - per-channel weighted products for luminosity: 77*R, 150*G, 29*B, each C+8 bits;
  - channel sum R+G+B, C+2 bits;
  - max(R,G,B);
  - the original pixel and the mode.
- S2 computes from S1 and registers O_PIXEL:
  - Mode 0: Y = (77R+150G+29B) >> 8.
  - Mode 1: Y = ((R+G+B)*171) >> 9, saturated to 2^C-1 if it exceeds C bits (possible for C>8).
  - Mode 2: Y = max(R,G,B).
  - Mode 3: O_PIXEL = original pixel, unchanged.
  - All arithmetic is unsigned. Intermediates are sized to avoid overflow. Results are truncated (floor), never rounded.
- Mode changes: the mode travels with its pixel, so changing I_MODE between pixels affects only pixels accepted after the change.
- O_PIXEL_COUNT: increments by 1 on each output transfer and wraps from 2^P_COUNT_WIDTH-1 to 0.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured. Reset has priority over everything.

Test Plan:
1. Reset, then I_PIXEL={FF,7F,00}, mode 0, single valid, I_OUT_READY=1 -> O_OUT_VALID high exactly 2 cycles later, O_PIXEL={97,97,97} (151), O_PIXEL_COUNT=1.
2. Same pixel in modes 1, 2, 3 on back-to-back cycles -> outputs on consecutive cycles: {7F,7F,7F}, {FF,FF,FF}, {FF,7F,00}. Then {FF,FF,FF} in mode 0 -> {FF,FF,FF}, and {01,01,01} in mode 1 -> {01,01,01}.
3. Stream of 8 distinct pixels with I_OUT_READY toggling pseudo-randomly and I_IN_VALID gapped -> scoreboard matches a reference model in order; O_PIXEL stable while stalled; O_PIXEL_COUNT=8.
4. I_OUT_READY held 0 with continuous input -> exactly 2 pixels accepted, then O_IN_READY=0. On release, both pixels drain in order with no loss or duplication.
5. P_PIXEL_DEPTH=48, mode 1, pixel {FFFF,FFFF,FFFF} -> saturated {FFFF,FFFF,FFFF}. Mode 0 on the same pixel -> {FFFF,FFFF,FFFF}.
6. Assert I_RESET while 2 pixels are in flight and the output is stalled -> next cycle O_OUT_VALID=0, O_PIXEL=0, O_PIXEL_COUNT=0, and no stale pixel appears afterwards. P_COUNT_WIDTH=3 with 9 transfers -> count wraps to 1.
